// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// Holds the FSM state enum, stall-mode encoding and LFSR constants.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  // Mode 3 is reserved and behaves like STALL_NONE.
  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_FIXED  = 2'd1,
    STALL_RANDOM = 2'd2
  } stall_mode_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
  endfunction

endpackage

// File: rtl/axis_lfsr16.sv
// Free-running 16-bit Galois LFSR used to draw pseudo-random stall lengths.
// Advances on every clock; restarts from LFSR_SEED on reset.
module axis_lfsr16
  import axis_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= LFSR_SEED;
    else        out <= lfsr_step(out);
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: one command in, one packet of incrementing bytes out.
// Define AXIS_PKT_GEN_STALL_EN to build the fixed/pseudo-random inter-beat stall logic.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [TDEST_WIDTH-1:0]   cmd_dest,
  input  logic [7:0]               cmd_seed,
  input  logic [1:0]               cmd_stall_mode,
  input  logic [3:0]               cmd_stall_cycles,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [TDEST_WIDTH-1:0]   m_axis_tdest,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     pkt_done,
  output logic [15:0]              pkt_count
);

  localparam int                   BYTES   = TDATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  state_t                   state_q, state_d;
  logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [BYTES-1:0]         tkeep_q, tkeep_d;
  logic                     tlast_q, tlast_d;
  logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
  logic                     tvalid_q, tvalid_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     pkt_done_q, pkt_done_d;
  logic [15:0]              pkt_count_q, pkt_count_d;
  logic [7:0]               byte_q, byte_d;   // value of the first byte of the next beat
  logic [LEN_WIDTH-1:0]     left_q, left_d;   // bytes not yet loaded into a beat

  logic                     accept, handshake, load_beat;
  logic [7:0]               src_byte;
  logic [LEN_WIDTH-1:0]     src_left;
  logic [TDATA_WIDTH-1:0]   nb_data;
  logic [BYTES-1:0]         nb_keep;
  logic                     nb_last;
  logic [LEN_WIDTH-1:0]     nb_take;

  assign accept    = cmd_ready_q & cmd_valid;
  assign handshake = tvalid_q & m_axis_tready;

`ifdef AXIS_PKT_GEN_STALL_EN
  logic [15:0] lfsr;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]  stall_n;
  logic        unused_lfsr_hi;

  axis_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:4];

  always_comb begin
    case (mode_q)
      STALL_FIXED:  stall_n = cyc_q;
      STALL_RANDOM: stall_n = lfsr[3:0] & cyc_q;
      default:      stall_n = 4'd0;
    endcase
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^{cmd_stall_mode, cmd_stall_cycles};
`endif

  // The next beat is built from the command on acceptance, else from the running pointer.
  always_comb begin
    src_byte = accept ? cmd_seed : byte_q;
    src_left = accept ? cmd_len  : left_q;
    nb_data  = '0;
    nb_keep  = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (LEN_WIDTH'(i) < src_left) begin
        nb_keep[i]        = 1'b1;
        nb_data[8*i +: 8] = src_byte + 8'(i);
      end
    end
    nb_last = (src_left <= BYTES_L);
    nb_take = nb_last ? src_left : BYTES_L;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tdest_d     = tdest_q;
    tvalid_d    = tvalid_q;
    pkt_done_d  = 1'b0;
    pkt_count_d = pkt_count_q;
    byte_d      = byte_q;
    left_d      = left_q;
    load_beat   = 1'b0;
`ifdef AXIS_PKT_GEN_STALL_EN
    mode_d      = mode_q;
    cyc_d       = cyc_q;
    stall_cnt_d = stall_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          tdest_d = cmd_dest;
`ifdef AXIS_PKT_GEN_STALL_EN
          mode_d  = cmd_stall_mode;
          cyc_d   = cmd_stall_cycles;
`endif
          // A zero-length command is consumed without producing a packet.
          if (cmd_len != '0) begin
            state_d   = SEND;
            tvalid_d  = 1'b1;
            load_beat = 1'b1;
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (tlast_q) begin
            state_d     = IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            pkt_done_d  = 1'b1;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            load_beat = 1'b1;
`ifdef AXIS_PKT_GEN_STALL_EN
            if (stall_n != 4'd0) begin
              state_d     = STALL;
              tvalid_d    = 1'b0;
              stall_cnt_d = stall_n;
            end
`endif
          end
        end
      end
`ifdef AXIS_PKT_GEN_STALL_EN
      STALL: begin
        stall_cnt_d = stall_cnt_q - 4'd1;
        if (stall_cnt_q == 4'd1) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    if (load_beat) begin
      tdata_d = nb_data;
      tkeep_d = nb_keep;
      tlast_d = nb_last;
      byte_d  = src_byte + 8'(BYTES);
      left_d  = src_left - nb_take;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tdest_q     <= '0;
      tvalid_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      byte_q      <= '0;
      left_q      <= '0;
`ifdef AXIS_PKT_GEN_STALL_EN
      mode_q      <= '0;
      cyc_q       <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tdest_q     <= tdest_d;
      tvalid_q    <= tvalid_d;
      cmd_ready_q <= cmd_ready_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
      byte_q      <= byte_d;
      left_q      <= left_d;
`ifdef AXIS_PKT_GEN_STALL_EN
      mode_q      <= mode_d;
      cyc_q       <= cyc_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tvalid = tvalid_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: expected beats are queued at command issue
// and a negedge monitor checks every handshake, hold, stall gap and completion pulse.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_len = '0;
  logic [1:0]  cmd_dest = '0;
  logic [7:0]  cmd_seed = '0;
  logic [1:0]  cmd_stall_mode = '0;
  logic [3:0]  cmd_stall_cycles = '0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tdest;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        pkt_done;
  logic [15:0] pkt_count;

  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;  // 0 always ready, 1 random, 2 driven by the test
  logic [15:0] exp_count = '0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  dest;
    logic [1:0]  mode;
    logic [3:0]  cyc;
  } beat_t;

  beat_t exp_q[$];

  axis_pkt_gen #(.TDATA_WIDTH(32), .TDEST_WIDTH(2), .LEN_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_len          (cmd_len),
    .cmd_dest         (cmd_dest),
    .cmd_seed         (cmd_seed),
    .cmd_stall_mode   (cmd_stall_mode),
    .cmd_stall_cycles (cmd_stall_cycles),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tdest     (m_axis_tdest),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .pkt_done         (pkt_done),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

`ifdef AXIS_PKT_GEN_STALL_EN
  // Reference LFSR: seeded 0xACE1, one Galois step per clock outside reset.
  logic [15:0] lfsr_m = 16'hACE1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
  end
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expected_gap(input beat_t b);
`ifdef AXIS_PKT_GEN_STALL_EN
    case (b.mode)
      2'd1:    return int'(b.cyc);
      2'd2:    return int'(lfsr_m[3:0] & b.cyc);
      default: return 0;
    endcase
`else
    return (b.mode == 2'd3) ? 0 : 0;
`endif
  endfunction

  // Byte k of a packet is (seed + k) mod 256, packed four per beat, lane 0 lowest.
  task automatic push_packet(input int len, input logic [7:0] seed, input logic [1:0] dest,
                             input logic [1:0] mode, input logic [3:0] cyc);
    for (int b = 0; b * 4 < len; b++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < 4; l++) begin
        int k = b * 4 + l;
        if (k < len) begin
          e.data[8*l +: 8] = 8'(int'(seed) + k);
          e.keep[l]        = 1'b1;
        end
      end
      e.last = (b * 4 + 4 >= len);
      e.dest = dest;
      e.mode = mode;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic [1:0] dest,
                          input logic [1:0] mode, input logic [3:0] cyc);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", cmd_ready, 1);
      return;
    end
    cmd_len          = 16'(len);
    cmd_seed         = seed;
    cmd_dest         = dest;
    cmd_stall_mode   = mode;
    cmd_stall_cycles = cyc;
    cmd_valid        = 1'b1;
    push_packet(len, seed, dest, mode, cyc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (len != 0) begin
      check("first_tvalid", m_axis_tvalid, 1);
    end else begin
      check("len0_cmd_ready", cmd_ready, 1);
      check("len0_tvalid", m_axis_tvalid, 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) check("idle_wait", exp_q.size(), 0);
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0)      m_axis_tready = 1'b1;
      else if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    beat_t e;
    beat_t held;
    bit    hold_v = 0;
    bit    gap_act = 0;
    bit    pend_done = 0;
    int    gap_cnt = 0;
    int    gap_exp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hold_v    = 0;
        gap_act   = 0;
        pend_done = 0;
        exp_count = '0;
      end else begin
        if (pend_done) begin
          check("ready_after_last", cmd_ready, 1);
          check("idle_after_last", m_axis_tvalid, 0);
        end
        check("pkt_done", pkt_done, pend_done);
        check("pkt_count", pkt_count, exp_count);
        pend_done = 0;
        if (hold_v) begin
          check("hold_tvalid", m_axis_tvalid, 1);
          check("hold_tdata", m_axis_tdata, held.data);
          check("hold_tkeep", m_axis_tkeep, held.keep);
          check("hold_tlast", m_axis_tlast, held.last);
          check("hold_tdest", m_axis_tdest, held.dest);
        end
        hold_v = 0;
        if (gap_act) begin
          if (!m_axis_tvalid) begin
            gap_cnt++;
            if (gap_cnt > 16) begin
              check("gap_bound", gap_cnt, gap_exp);
              gap_act = 0;
            end
          end else begin
            check("gap_len", gap_cnt, gap_exp);
            gap_act = 0;
          end
        end
        if (m_axis_tvalid) begin
          if (m_axis_tready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_beat", m_axis_tvalid, 0);
            end else begin
              e = exp_q.pop_front();
              check("tdata", m_axis_tdata, e.data);
              check("tkeep", m_axis_tkeep, e.keep);
              check("tlast", m_axis_tlast, e.last);
              check("tdest", m_axis_tdest, e.dest);
              if (e.last) begin
                exp_count++;
                pend_done = 1;
              end else begin
                gap_act = 1;
                gap_cnt = 0;
                gap_exp = expected_gap(e);
              end
            end
          end else begin
            hold_v    = 1;
            held.data = m_axis_tdata;
            held.keep = m_axis_tkeep;
            held.last = m_axis_tlast;
            held.dest = m_axis_tdest;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tdest", m_axis_tdest, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_count", pkt_count, 0);
    rst_n = 1'b1;

    // Three-beat packet with a two-byte tail.
    send_cmd(10, 8'h00, 2'd2, 2'd0, 4'd0);
    wait_idle();
    check("pkt_count_first", pkt_count, 1);

    // Downstream back-pressure holds beat 0 for six cycles.
    rdy_mode      = 2;
    m_axis_tready = 1'b0;
    send_cmd(8, 8'hFE, 2'd1, 2'd0, 4'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("held_beat0", m_axis_tdata, 32'h0100FFFE);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("beat1_data", m_axis_tdata, 32'h05040302);
    check("beat1_last", m_axis_tlast, 1);
    rdy_mode = 0;
    wait_idle();

    // Fixed and pseudo-random stalls; gaps are checked by the monitor.
    send_cmd(12, 8'h10, 2'd3, 2'd1, 4'd3);
    wait_idle();
    send_cmd(64, 8'h5A, 2'd0, 2'd2, 4'hF);
    wait_idle();

    // Zero-length command is swallowed; a one-byte packet follows.
    send_cmd(0, 8'h33, 2'd1, 2'd0, 4'd0);
    check("len0_count", pkt_count, exp_count);
    send_cmd(1, 8'hAA, 2'd1, 2'd0, 4'd0);
    wait_idle();

    // Randomised commands under random back-pressure.
    for (int p = 0; p < 30; p++) begin
      rdy_mode = int'($urandom_range(0, 1));
      send_cmd(int'($urandom_range(0, 40)), 8'($urandom), 2'($urandom),
               2'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    rdy_mode = 0;
    wait_idle();

    // Reset during beat 2 of a five-beat packet truncates it.
    send_cmd(20, 8'h40, 2'd1, 2'd0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_pkt_count", pkt_count, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_pkt_done", pkt_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_cmd(4, 8'h77, 2'd2, 2'd0, 4'd0);
    wait_idle();
    check("post_rst_count", pkt_count, 1);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Synthesisable, parametrised AXI-Stream packet generator: accepts one command at a time (byte length, destination, pattern seed, stall mode) and emits the packet on an AXI-Stream master port with tkeep, tlast and tdest. Holds tvalid and tdata until tready, and can insert fixed or pseudo-random inter-beat stalls. Sits at the ingress of the packet router in benches and on-chip self-test, replacing task-driven stimulus.

## Interface
- TDATA_WIDTH, 32, data width in bits; must be a multiple of 8; BYTES = TDATA_WIDTH/8.
- TDEST_WIDTH, 2, destination (output channel) width.
- LEN_WIDTH, 16, width of the packet length in bytes.
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready; high only in IDLE.
- cmd_len  in  LEN_WIDTH  packet length in bytes.
- cmd_dest  in  TDEST_WIDTH  tdest for every beat of the packet.
- cmd_seed  in  8  value of packet byte 0.
- cmd_stall_mode  in  2  0 none, 1 fixed, 2 random, 3 treated as none.
- cmd_stall_cycles  in  4  fixed stall length, or random mask.
- m_axis_tdata  out  TDATA_WIDTH  beat data, byte lane 0 at [7:0].
- m_axis_tkeep  out  BYTES  valid byte lanes.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tdest  out  TDEST_WIDTH  packet destination.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- pkt_done  out  1  one-cycle pulse on the cycle after the tlast handshake.
- pkt_count  out  16  packets completed, wraps 0xFFFF to 0.

## Operation
- FSM states IDLE, SEND, STALL.
- IDLE: cmd_ready=1. On cmd_valid: latch all cmd fields. cmd_len=0: command consumed, nothing emitted, no pkt_done, stay IDLE. Otherwise go to SEND.
- SEND: tvalid=1. tdata, tkeep, tlast and tdest stay stable until the handshake (tvalid & tready).
- On handshake of a non-last beat: if the computed stall N>0, go to STALL; otherwise stay in SEND with the next beat.
- On handshake of the last beat: go to IDLE, increment pkt_count, pulse pkt_done.
- STALL: tvalid=0 for exactly N cycles, then SEND.
- No stall is inserted after the last beat.
- Stall N for fixed mode = cmd_stall_cycles. For random mode, N = lfsr[3:0] & cmd_stall_cycles, sampled at the handshake.
- Packet byte k = (cmd_seed + k) mod 256. Beat b carries bytes b*BYTES .. b*BYTES+BYTES-1.
- Beat count = ceil(cmd_len/BYTES). The last beat has tkeep = low (cmd_len mod BYTES) lanes set, or all lanes if the remainder is 0. Non-kept lanes carry tdata 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, reset value 16'hACE1. Advances every cycle regardless of state.

## Timing
- Reset values: cmd_ready=0 while rst_n is low, then 1 (IDLE). tvalid=0, tlast=0, tdata=0, tkeep=0, tdest=0, pkt_done=0, pkt_count=0, LFSR=16'hACE1.
- All outputs are registered. First tvalid appears the cycle after command acceptance.
- With no stalls and tready held high, the generator sends one beat per cycle.
- After the last beat's handshake, cmd_ready is high on the next cycle. There is at least one idle cycle between packets.
- tready low never changes the presented beat. tready is ignored while tvalid=0.
- Reset asserted mid-packet: tvalid drops asynchronously, the packet is truncated, no pkt_done is produced, and the FSM returns to IDLE.

## Configuration
- AXIS_PKT_GEN_STALL_EN defined: STALL state, the stall counter and the LFSR are built, and cmd_stall_mode and cmd_stall_cycles behave as above.
- AXIS_PKT_GEN_STALL_EN undefined: no STALL state and no LFSR. cmd_stall_mode and cmd_stall_cycles are ignored, so beats are back-to-back, gated only by tready.

## Structure
- Package axis_pkt_gen_pkg holds:
  - the state enum (IDLE/SEND/STALL);
  - the stall-mode enum (STALL_NONE/FIXED/RANDOM);
  - LFSR_POLY = 16'hB400 and LFSR_SEED = 16'hACE1.
- One sub-module, axis_lfsr16 (clk, rst_n, out[15:0]), instantiated only under AXIS_PKT_GEN_STALL_EN.

## Test plan
All scenarios use TDATA_WIDTH=32.
- Command len=10, seed=0x00, dest=2, mode 0, tready=1 → three beats 0x03020100/keep F, 0x07060504/keep F, 0x00000908/keep 3 with tlast. tdest=2 on all beats. pkt_done pulses once and pkt_count=1.
- len=8, seed=0xFE, tready low for 5 cycles at beat 0 → beat 0 (0x0100FFFE) held stable for 6 cycles. Beat 1 = 0x05040302 with tlast, keep F.
- len=12, mode 1, stall_cycles=3, tready=1 → tvalid pattern 1,0,0,0,1,0,0,0,1. No gap follows the last beat.
- mode 2, stall_cycles=0xF, len=64 → every gap is ≤15 cycles and the data sequence is intact. The gap sequence matches a reference LFSR model seeded 0xACE1.
- len=0 command → cmd_ready stays high, no tvalid, pkt_count unchanged. A following len=1, seed=0xAA command → a single beat 0x000000AA with keep 1 and tlast.
- rst_n pulled low during beat 2 of a 5-beat packet → tvalid=0 immediately and pkt_count=0. After release, a new len=4 packet emits cleanly.
